spi_ram_loader: RTL and testbench
=================================

# spi_ram_loader

SPI-slave boot loader between an external debug SPI master, the single-port-write SRAM and the CPU of the subservient SoC. While the master holds chip-select low, incoming bytes are written sequentially into SRAM from address 0 and the CPU is held in reset. When chip-select rises, the CPU is released and regains the SRAM write port. All logic runs in the system clock domain; the SPI pins are asynchronous inputs.

## Interface
- aw, 8, SRAM byte-address width; memory depth is 2**aw bytes.
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_sclk  in  1  SPI clock, asynchronous, mode 0 (sample on rising edge).
- i_cs_n  in  1  SPI chip-select, asynchronous, active-low.
- i_mosi  in  1  SPI data, MSB first.
- i_cpu_waddr  in  aw  CPU SRAM write address.
- i_cpu_wdata  in  8  CPU SRAM write data.
- i_cpu_wen  in  1  CPU SRAM write enable.
- o_sram_waddr  out  aw  muxed SRAM write address.
- o_sram_wdata  out  8  muxed SRAM write data.
- o_sram_wen  out  1  muxed SRAM write enable.
- o_cpu_rst  out  1  active-high CPU reset.
- o_loading  out  1  high while a load frame is in progress.

## Operation
- i_sclk, i_cs_n and i_mosi each pass through a 2-flop synchronizer. Synchronizer resets: sclk 0, cs_n 1, mosi 0.
- Edge detection uses the synchronized values and their previous-cycle copies.
- cs_n falling edge starts a frame:
  - address counter := 0
  - bit counter := 0
  - o_loading := 1
  - o_cpu_rst := 1
- sclk rising edge while synchronized cs_n is low:
  - shift register := {shift[6:0], mosi}
  - bit counter increments.
- On the 8th bit:
  - write pulse fires (see Timing); o_sram_wdata = assembled byte, o_sram_waddr = address counter.
  - Address counter then increments modulo 2**aw; writing past the end wraps to 0 and overwrites.
  - Bit counter returns to 0.
- cs_n rising edge ends the frame:
  - o_loading := 0
  - o_cpu_rst := 0
  - A partial byte (1–7 bits) is discarded and not written.
- Write-port mux:
  - o_loading=1: SRAM write port driven by the loader; i_cpu_wen is ignored.
  - o_loading=0: i_cpu_* passed through combinationally.
- sclk edges while cs_n is high are ignored.
- A cs_n low pulse with no sclk edges still restarts the CPU and writes nothing.
- Reset values: o_loading=0, o_cpu_rst=1, loader write enable 0, counters and shift register 0.
  - The CPU stays in reset after power-up until the first frame completes, because RAM contents are undefined before a load.
- Assertion of i_rst_n (low) mid-frame:
  - abort the frame; outputs return to reset values.
  - A new cs_n falling edge is needed to load again; cs_n already low at reset release does not start a frame.

## Timing
- Synchronizer latency: an SPI pin change is seen by the edge detector 2 cycles later and acted on in the 3rd cycle.
- Loader write enable is registered. It is high for exactly one i_clk cycle, the cycle after the 8th sclk rising edge is detected. Address and data are stable during that cycle.
- o_loading and o_cpu_rst change in the same cycle the cs_n edge is detected.
  - On cs_n rise, a write pulse still pending from the final byte completes first: o_loading falls no earlier than the cycle after the last loader write.
- Constraint on the master: sclk high and low phases ≥ 3 i_clk periods each; cs_n setup/hold to sclk ≥ 3 i_clk periods.

## Structure
- Single module spi_ram_loader.
- One natural sub-module: spi_ram_loader_sync, a parameterized-reset-value 2-flop synchronizer instantiated three times.
- No shared package needed. The bit-count constant 8 may be a localparam.

## Test plan
- Reset then idle: i_rst_n low 2 cycles, then high with cs_n=1 → o_cpu_rst=1, o_loading=0, o_sram_wen follows i_cpu_wen.
- Load bytes 0x13, 0xA5, 0xFF: cs_n low, 24 bits MSB-first, cs_n high → three wen pulses at addresses 0,1,2 with data 0x13,0xA5,0xFF; then o_cpu_rst=0.
- Partial byte: 8 bits 0x5A then 3 bits → only address 0 written with 0x5A; frame ends, CPU released.
- Wrap-around with aw=2: 5 bytes 0x01..0x05 → writes to addresses 0,1,2,3,0; address 0 finally holds 0x05.
- CPU write blocked during load: i_cpu_wen=1 at address 3, data 0x77, asserted mid-frame → no write to 3 while o_loading=1; passes through after cs_n rises.
- Reset mid-frame: drop i_rst_n after 12 bits → no further writes; o_cpu_rst=1 and o_loading=0 after reset; a fresh frame starts again at address 0.

Source files
------------

// File: rtl/spi_ram_loader_pkg.sv
// rtl/spi_ram_loader_pkg.sv - shared constants and state encoding for the SPI boot loader
package spi_ram_loader_pkg;

  localparam int BITS_PER_BYTE = 8;
  localparam int BIT_CNT_W     = $clog2(BITS_PER_BYTE);

  // RESET: CPU held, cs_n not yet seen genuinely high; BOOT: CPU held, armed for a frame
  typedef enum logic [1:0] {
    ST_RESET,
    ST_BOOT,
    ST_LOAD,
    ST_RUN
  } state_t;

endpackage

// File: rtl/spi_ram_loader_sync.sv
// rtl/spi_ram_loader_sync.sv - 2-flop synchronizer with a selectable reset value
module spi_ram_loader_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_ram_loader.sv
// rtl/spi_ram_loader.sv - SPI-slave loader writing bytes into SRAM while holding the CPU in reset
module spi_ram_loader
  import spi_ram_loader_pkg::*;
#(
  parameter int aw = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_sclk,
  input  logic          i_cs_n,
  input  logic          i_mosi,
  input  logic [aw-1:0] i_cpu_waddr,
  input  logic [7:0]    i_cpu_wdata,
  input  logic          i_cpu_wen,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic          o_cpu_rst,
  output logic          o_loading
);

  logic                 sclk_s, cs_n_s, mosi_s;
  logic                 sclk_d, cs_n_d;
  logic [1:0]           settle;
  state_t               state, next;
  logic [aw-1:0]        addr;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shift;
  logic                 ld_wen;
  logic                 loading, cs_fall, sclk_rise, bit_in, byte_done;

  spi_ram_loader_sync #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(i_clk), .rst_n(i_rst_n), .d(i_sclk), .q(sclk_s));
  spi_ram_loader_sync #(.RESET_VAL(1'b1)) u_sync_cs_n (.clk(i_clk), .rst_n(i_rst_n), .d(i_cs_n), .q(cs_n_s));
  spi_ram_loader_sync #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(i_clk), .rst_n(i_rst_n), .d(i_mosi), .q(mosi_s));

  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = cs_n_d & ~cs_n_s;
  assign loading   = (state == ST_LOAD);
  assign bit_in    = loading & ~cs_n_s & sclk_rise;
  assign byte_done = bit_in && (bit_cnt == BIT_CNT_W'(BITS_PER_BYTE - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_RESET;
    else          state <= next;
  end

  // The synchronizer's reset value of cs_n is not a real observation of the pin,
  // so a frame may only start after cs_n has been seen high once it has settled.
  always_comb begin
    next      = state;
    o_loading = 1'b0;
    o_cpu_rst = 1'b1;
    case (state)
      ST_RESET: if (settle[1] && cs_n_s) next = ST_BOOT;
      ST_BOOT:  if (cs_fall) next = ST_LOAD;
      ST_LOAD: begin
        o_loading = 1'b1;
        if (cs_n_s) next = ST_RUN;
      end
      ST_RUN: begin
        o_cpu_rst = 1'b0;
        if (cs_fall) next = ST_LOAD;
      end
      default: next = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sclk_d  <= 1'b0;
      cs_n_d  <= 1'b1;
      settle  <= 2'b00;
      addr    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      ld_wen  <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
      settle <= {settle[0], 1'b1};
      ld_wen <= byte_done;
      if (next == ST_LOAD && !loading) begin
        addr    <= '0;
        bit_cnt <= '0;
      end else begin
        // Address advances after the write cycle so it is stable while wen is high.
        if (ld_wen) addr <= addr + aw'(1);
        if (bit_in) begin
          shift   <= {shift[6:0], mosi_s};
          bit_cnt <= byte_done ? '0 : bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

  assign o_sram_wen   = loading ? ld_wen : i_cpu_wen;
  assign o_sram_waddr = loading ? addr   : i_cpu_waddr;
  assign o_sram_wdata = loading ? shift  : i_cpu_wdata;

endmodule

// File: tb/tb_spi_ram_loader.sv
// tb/tb_spi_ram_loader.sv - randomized SPI frames checked against a byte-level scoreboard
module tb_spi_ram_loader;

  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic [AW-1:0] cpu_waddr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_wen = 1'b0;
  logic [AW-1:0] o_sram_waddr;
  logic [7:0]    o_sram_wdata;
  logic          o_sram_wen;
  logic          o_cpu_rst;
  logic          o_loading;

  int n_pass = 0;
  int n_total = 0;
  int dbl = 0;
  int leak = 0;
  logic prev_wen = 1'b0;

  logic [7:0]      tx_q[$];
  logic [AW+7:0]   obs_q[$];
  logic [AW+7:0]   exp_q[$];
  logic [7:0]      dut_mem[DEPTH];
  logic [7:0]      model_mem[DEPTH];

  spi_ram_loader #(.aw(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata), .i_cpu_wen(cpu_wen),
    .o_sram_waddr(o_sram_waddr), .o_sram_wdata(o_sram_wdata), .o_sram_wen(o_sram_wen),
    .o_cpu_rst(o_cpu_rst), .o_loading(o_loading)
  );

  always #5 clk = ~clk;

  // Loader writes are those seen while o_loading is high.
  always @(negedge clk) begin
    if (o_loading && o_sram_wen) begin
      obs_q.push_back({o_sram_waddr, o_sram_wdata});
      dut_mem[o_sram_waddr] <= o_sram_wdata;
      if (prev_wen) dbl <= dbl + 1;
      if (o_sram_waddr == AW'(3) && o_sram_wdata == 8'h77) leak <= leak + 1;
    end
    prev_wen <= o_loading && o_sram_wen;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_frame(input int nbits, input int abort_at);
    int nfull;
    bit aborted;
    aborted = 1'b0;
    cs_n = 1'b0;
    cyc($urandom_range(3, 6));
    for (int k = 0; k < nbits; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        cyc(2);
        chk("rst_loading", o_loading, 0);
        chk("rst_cpu_rst", o_cpu_rst, 1);
        rst_n = 1'b1;
        cyc(10);
        chk("no_restart", o_loading, 0);
        aborted = 1'b1;
        break;
      end
      mosi = tx_q[k / 8][7 - (k % 8)];
      cyc($urandom_range(3, 6));
      if (k == 0) begin
        chk("mid_loading", o_loading, 1);
        chk("mid_cpu_rst", o_cpu_rst, 1);
      end
      sclk = 1'b1;
      cyc($urandom_range(3, 6));
      sclk = 1'b0;
    end
    cyc($urandom_range(3, 6));
    cs_n = 1'b1;
    cyc(8);
    nfull = (aborted ? abort_at : nbits) / 8;
    for (int j = 0; j < nfull; j++) begin
      exp_q.push_back({AW'(j % DEPTH), tx_q[j]});
      model_mem[j % DEPTH] = tx_q[j];
    end
    chk("nwrites", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk("write", obs_q[i], exp_q[i]);
    chk("end_loading", o_loading, 0);
    chk("end_cpu_rst", o_cpu_rst, aborted ? 1 : 0);
    obs_q.delete();
    exp_q.delete();
    tx_q.delete();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dut_mem[i] = 8'h00;
      model_mem[i] = 8'h00;
    end

    cyc(2);
    chk("reset_cpu_rst", o_cpu_rst, 1);
    chk("reset_loading", o_loading, 0);
    rst_n = 1'b1;
    cyc(5);
    chk("idle_cpu_rst", o_cpu_rst, 1);
    chk("idle_wen0", o_sram_wen, 0);
    cpu_waddr = AW'(2); cpu_wdata = 8'h3c; cpu_wen = 1'b1;
    cyc(1);
    chk("idle_wen1", o_sram_wen, 1);
    chk("idle_waddr", o_sram_waddr, 2);
    chk("idle_wdata", o_sram_wdata, 8'h3c);
    cpu_wen = 1'b0;

    tx_q = '{8'h13, 8'hA5, 8'hFF};
    spi_frame(24, -1);

    tx_q = '{8'h5A, 8'($urandom)};
    spi_frame(11, -1);

    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    spi_frame(40, -1);
    for (int i = 0; i < DEPTH; i++) chk("wrap_mem", dut_mem[i], model_mem[i]);
    chk("wrap_mem0", dut_mem[0], 8'h05);

    tx_q = '{8'($urandom), 8'($urandom)};
    fork
      spi_frame(16, -1);
      begin
        cyc(20);
        cpu_waddr = AW'(3); cpu_wdata = 8'h77; cpu_wen = 1'b1;
      end
    join
    chk("cpu_pass_wen", o_sram_wen, 1);
    chk("cpu_pass_addr", o_sram_waddr, 3);
    chk("cpu_pass_data", o_sram_wdata, 8'h77);
    cpu_wen = 1'b0;
    cyc(1);
    chk("cpu_pass_off", o_sram_wen, 0);

    tx_q = '{8'($urandom), 8'($urandom)};
    spi_frame(20, 12);
    cs_n = 1'b0;
    cyc(6);
    cs_n = 1'b1;
    cyc(8);
    chk("pulse_cpu_rst", o_cpu_rst, 0);
    chk("pulse_nwrites", obs_q.size(), 0);
    tx_q = '{8'($urandom), 8'($urandom)};
    spi_frame(16, -1);

    for (int i = 0; i < 6; i++) begin
      sclk = 1'b1; cyc(4);
      sclk = 1'b0; cyc(4);
    end
    chk("idle_sclk_nwrites", obs_q.size(), 0);

    for (int r = 0; r < 6; r++) begin
      int nb, extra;
      nb = $urandom_range(1, 6);
      extra = $urandom_range(0, 7);
      for (int j = 0; j <= nb; j++) tx_q.push_back(8'($urandom));
      spi_frame(nb * 8 + extra, -1);
    end

    chk("wen_width", dbl, 0);
    chk("cpu_leak", leak, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
